// File: rtl/state_readout.sv
// state_readout: streams the full state vector out of a synchronous state
// memory as indexed beats on a valid/ready port. Reads are credit-limited so
// the 2-entry output FIFO can never overflow, yet m_ready held high still
// gives one beat per cycle.
// Optional feature: define STATE_READOUT_MAG2_EN to compute and stream
// m_mag2 = re^2 + im^2 with each beat. Without it m_mag2 is tied to 0 and no
// multipliers exist.
module state_readout #(
    parameter int N_QUBITS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic [N_QUBITS-1:0]        mem_addr,
    input  logic signed [15:0]         mem_r,
    input  logic signed [15:0]         mem_i,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [N_QUBITS-1:0]        m_index,
    output logic signed [15:0]         m_re,
    output logic signed [15:0]         m_im,
    output logic                       m_last,
    output logic [31:0]                m_mag2,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                stall_count
);

    localparam int AW  = N_QUBITS;
    localparam int DIM = 1 << N_QUBITS;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } state_t;

    // One FIFO entry: amplitude tagged with its basis-state index.
    typedef struct packed {
        logic [AW-1:0]       index;
        logic signed [15:0]  re;
        logic signed [15:0]  im;
        logic                last;
`ifdef STATE_READOUT_MAG2_EN
        logic [31:0]         mag2;
`endif
    } beat_t;

    state_t          state;
    logic            rd_pend;      // a read was issued last edge; data is on mem_r/mem_i now
    logic [AW-1:0]   rd_idx;       // index of that in-flight read
    beat_t           fifo [2];
    logic            wr_sel;
    logic            rd_sel;
    logic [1:0]      occ;
    beat_t           head;
    beat_t           new_beat;
    logic            push;
    logic            pop;
    logic            issue;
    logic [2:0]      credit;

    assign head    = fifo[rd_sel];
    assign m_valid = (occ != 2'd0);
    assign m_index = head.index;
    assign m_re    = head.re;
    assign m_im    = head.im;
    assign m_last  = head.last;

    assign push = rd_pend;
    assign pop  = m_valid & m_ready;

    // Occupancy counted net of the beat leaving on this edge, so a pop frees
    // its slot for a read issued on the same edge; that is what sustains one
    // beat per cycle with only two credits.
    assign credit = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
    assign issue  = (state == READ) && (credit < 3'd2);

`ifdef STATE_READOUT_MAG2_EN
    logic signed [31:0] sq_r;
    logic signed [31:0] sq_i;
    logic [31:0]        mag2_calc;

    // Full-precision squares; the sum peaks at 2^31 so 32 unsigned bits suffice.
    assign sq_r      = 32'(mem_r) * 32'(mem_r);
    assign sq_i      = 32'(mem_i) * 32'(mem_i);
    assign mag2_calc = $unsigned(sq_r) + $unsigned(sq_i);
    assign m_mag2    = head.mag2;
`else
    assign m_mag2    = 32'd0;
`endif

    // Assemble the beat captured from the memory read port.
    always_comb begin
        // NOTE: full default first so no path leaves a field unassigned (no latch).
        new_beat       = '0;
        new_beat.index = rd_idx;
        new_beat.re    = mem_r;
        new_beat.im    = mem_i;
        new_beat.last  = (rd_idx == AW'(DIM - 1));
`ifdef STATE_READOUT_MAG2_EN
        new_beat.mag2  = mag2_calc;
`endif
    end

    // Control FSM: read pointer, busy/done, stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            stall_count <= '0;
        end else begin
            // NOTE: non-blocking throughout; a later assignment in this block
            // (e.g. the clear on start) wins over the earlier default.
            done <= 1'b0;
            if (m_valid && !m_ready && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= READ;
                        mem_addr    <= '0;
                        stall_count <= '0;
                        busy        <= 1'b1;
                    end
                end
                READ: begin
                    if (issue) begin
                        // The pointer parks on the last address instead of wrapping.
                        if (mem_addr == AW'(DIM - 1))
                            state <= DRAIN;
                        else
                            mem_addr <= mem_addr + AW'(1);
                    end
                end
                DRAIN: begin
                    if (pop && head.last) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read pipeline tracking and the 2-entry output FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_idx  <= '0;
            occ     <= 2'd0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            // NOTE: the FIFO storage is reset because the head drives m_* directly
            // and those must read zero in reset; storage is only two entries.
            fifo[0] <= '0;
            fifo[1] <= '0;
        end else begin
            rd_pend <= issue;
            if (issue)
                rd_idx <= mem_addr;
            if (push) begin
                fifo[wr_sel] <= new_beat;
                wr_sel       <= ~wr_sel;
            end
            if (pop)
                rd_sel <= ~rd_sel;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_state_readout.sv
// tb_state_readout: directed bench for state_readout. A synchronous memory
// model feeds the read port; every beat is compared against the bench's own
// copy of the memory contents. Build with STATE_READOUT_MAG2_EN defined to
// exercise the magnitude datapath.
module tb_state_readout;

    localparam int N_QUBITS = 4;
    localparam int DIM      = 16;
    localparam int AW       = 4;

`ifdef STATE_READOUT_MAG2_EN
    localparam logic [31:0] MAG2_EXTREME = 32'h8000_0000;
`else
    localparam logic [31:0] MAG2_EXTREME = 32'h0000_0000;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 m_ready = 1'b0;
    logic [AW-1:0]        mem_addr;
    logic signed [15:0]   mem_r;
    logic signed [15:0]   mem_i;
    logic                 m_valid;
    logic [AW-1:0]        m_index;
    logic signed [15:0]   m_re;
    logic signed [15:0]   m_im;
    logic                 m_last;
    logic [31:0]          m_mag2;
    logic                 busy;
    logic                 done;
    logic [31:0]          stall_count;

    logic signed [15:0]   mem_re [DIM];
    logic signed [15:0]   mem_im [DIM];

    int checks = 0;
    int errors = 0;
    int exp_idx, n_beats, n_done, stalls_seen, cyc_no;
    int first_valid, first_xfer, last_xfer, done_cyc;
    logic extreme = 1'b0;
    logic prev_stall = 1'b0;
    logic [AW-1:0]      hold_idx;
    logic signed [15:0] hold_re, hold_im;
    logic               hold_last;
    logic [31:0]        hold_mag2;

    state_readout #(.N_QUBITS(N_QUBITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_r       (mem_r),
        .mem_i       (mem_i),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_index     (m_index),
        .m_re        (m_re),
        .m_im        (m_im),
        .m_last      (m_last),
        .m_mag2      (m_mag2),
        .busy        (busy),
        .done        (done),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    // Synchronous state memory: data for the address sampled at an edge appears after it.
    always @(posedge clk) begin
        mem_r <= mem_re[mem_addr];
        mem_i <= mem_im[mem_addr];
    end

    function automatic logic [31:0] exp_mag2(input logic signed [15:0] r, input logic signed [15:0] i);
`ifdef STATE_READOUT_MAG2_EN
        logic signed [31:0] rr;
        logic signed [31:0] ii;
        rr = 32'(r) * 32'(r);
        ii = 32'(i) * 32'(i);
        return $unsigned(rr) + $unsigned(ii);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe the current cycle (called at a negedge, outputs settled).
    task automatic observe(input logic rdy);
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc_no;
        end
        if (m_valid === 1'b1) begin
            if (first_valid < 0)
                first_valid = cyc_no;
            if (prev_stall) begin
                check("hold_index", m_index, hold_idx);
                check("hold_re",    m_re,    hold_re);
                check("hold_im",    m_im,    hold_im);
                check("hold_last",  m_last,  hold_last);
                check("hold_mag2",  m_mag2,  hold_mag2);
            end
            if (rdy) begin
                check("beat_index", m_index, exp_idx);
                check("beat_re",    m_re,    mem_re[exp_idx % DIM]);
                check("beat_im",    m_im,    mem_im[exp_idx % DIM]);
                check("beat_last",  m_last,  exp_idx == DIM - 1);
                check("beat_mag2",  m_mag2,  exp_mag2(mem_re[exp_idx % DIM], mem_im[exp_idx % DIM]));
                if (extreme && exp_idx == 3)
                    check("mag2_extreme", m_mag2, MAG2_EXTREME);
                if (first_xfer < 0)
                    first_xfer = cyc_no;
                last_xfer = cyc_no;
                exp_idx++;
                n_beats++;
                prev_stall = 1'b0;
            end else begin
                stalls_seen++;
                prev_stall = 1'b1;
                hold_idx   = m_index;
                hold_re    = m_re;
                hold_im    = m_im;
                hold_last  = m_last;
                hold_mag2  = m_mag2;
            end
        end else begin
            prev_stall = 1'b0;
        end
    endtask

    // Drive one cycle's inputs, observe, advance to the next negedge.
    task automatic cyc(input logic rdy, input logic st);
        m_ready = rdy;
        start   = st;
        observe(rdy);
        @(negedge clk);
        cyc_no++;
    endtask

    task automatic clear_counts();
        exp_idx     = 0;
        n_beats     = 0;
        n_done      = 0;
        stalls_seen = 0;
        cyc_no      = 0;
        first_valid = -1;
        first_xfer  = -1;
        last_xfer   = -1;
        done_cyc    = -1;
        prev_stall  = 1'b0;
    endtask

    // mode 0: ready high; 1: ready 1,0,1,0 from the cycle after E1;
    // 2: ready low until ten stall cycles; 3: ready high, second start at beat 5.
    task automatic run_dump(input int mode, input int exp_stalls);
        logic rdy;
        logic st;
        logic restarted;
        logic mid_checked;
        int   guard;
        clear_counts();
        restarted   = 1'b0;
        mid_checked = 1'b0;
        guard       = 0;
        cyc(1'b0, 1'b1);
        check("e0_busy",     busy,     1);
        check("e0_mem_addr", mem_addr, 0);
        check("e0_valid",    m_valid,  0);
        while (n_done == 0 && guard < 200) begin
            case (mode)
                1:       rdy = (cyc_no % 2 == 0);
                2:       rdy = (stalls_seen >= 10);
                default: rdy = 1'b1;
            endcase
            if (mode == 2 && stalls_seen == 10 && !mid_checked) begin
                mid_checked = 1'b1;
                check("stall_valid",  m_valid,  1);
                check("stall_index",  m_index,  0);
                check("reads_issued", mem_addr, 2);
            end
            st = (mode == 3) && (n_beats == 5) && !restarted;
            if (st)
                restarted = 1'b1;
            cyc(rdy, st);
            guard++;
        end
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 1'b0);
        check("done_count",  n_done,      1);
        check("beat_count",  n_beats,     DIM);
        check("first_valid", first_valid, 3);
        check("stall_count", stall_count, exp_stalls);
        check("end_busy",    busy,        0);
        check("end_valid",   m_valid,     0);
        if (mode == 0) begin
            check("back_to_back", last_xfer - first_xfer, DIM - 1);
            check("done_after_last", done_cyc, last_xfer + 1);
        end
    endtask

    initial begin
        // Reset state while rst_n is held low.
        #12;
        check("rst_valid",   m_valid,     0);
        check("rst_busy",    busy,        0);
        check("rst_done",    done,        0);
        check("rst_addr",    mem_addr,    0);
        check("rst_index",   m_index,     0);
        check("rst_re",      m_re,        0);
        check("rst_im",      m_im,        0);
        check("rst_last",    m_last,      0);
        check("rst_mag2",    m_mag2,      0);
        check("rst_stall",   stall_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // |0000> = (0x4000, 0), full-rate drain.
        for (int k = 0; k < DIM; k++) begin
            mem_re[k] = 16'sd0;
            mem_im[k] = 16'sd0;
        end
        mem_re[0] = 16'sh4000;
        run_dump(0, 0);

        // mem[k] = (k, -k), alternating ready.
        for (int k = 0; k < DIM; k++) begin
            mem_re[k] = 16'(k);
            mem_im[k] = 16'(-k);
        end
        run_dump(1, 16);

        // Downstream blocked for ten valid cycles.
        for (int k = 0; k < DIM; k++) begin
            mem_re[k] = 16'(k * 256);
            mem_im[k] = 16'(100 - k);
        end
        run_dump(2, 10);

        // Reset while index 7 is pending.
        clear_counts();
        cyc(1'b0, 1'b1);
        for (int g = 0; g < 60 && n_beats < 7; g++)
            cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("pend_valid", m_valid,     1);
        check("pend_index", m_index,     7);
        check("pend_stall", stall_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", m_valid,     0);
        check("midrst_busy",  busy,        0);
        check("midrst_done",  done,        0);
        check("midrst_addr",  mem_addr,    0);
        check("midrst_index", m_index,     0);
        check("midrst_stall", stall_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_stall = 1'b0;
        for (int k = 0; k < 5; k++)
            cyc(1'b1, 1'b0);
        check("post_rst_beats", n_beats, 7);
        check("post_rst_done",  n_done,  0);
        run_dump(0, 0);

        // Second start during the dump is ignored; extreme amplitude at index 3.
        for (int k = 0; k < DIM; k++) begin
            mem_re[k] = 16'(k);
            mem_im[k] = 16'(-k);
        end
        mem_re[3] = 16'sh8000;
        mem_im[3] = 16'sh8000;
        extreme = 1'b1;
        run_dump(3, 0);
        extreme = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
